// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, Cause/Status field positions and
// the interrupt sequencer state encoding.
package cp0_pkg;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int CAUSE_IP_BASE = 8;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;
  localparam int STATUS_IE     = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_EPC,
    S_SAVE_CAUSE,
    S_ENTER,
    S_IN_SVC,
    S_RETURN
  } state_t;
endpackage

// File: rtl/irq_prio_latch.sv
// Rising-edge capture of device IRQ lines into a pending register, plus a
// lowest-index-wins priority encoder over the pending set.
module irq_prio_latch #(
  parameter int NIRQ = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] irq_clr,
  input  logic [NIRQ-1:0] ack,
  output logic            any_pending,
  output logic [2:0]      winner
);
  logic [NIRQ-1:0] irq_q, pending, rise;

  assign rise = irq_in & ~irq_q;

  // OR-ing rise last lets a fresh edge beat a same-cycle cancel or ack.
  always_ff @(posedge clk) begin
    if (clr) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~irq_clr & ~ack) | rise;
    end
  end

  assign any_pending = |pending;

  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (pending[i]) winner = 3'(i);
  end
endmodule

// File: rtl/cp0_int_ctrl.sv
// Interrupt entry/return sequencer: saves EPC and Cause through the CP0 write
// port, masks IE, vectors fetch to the line handler, and unwinds on ERET.
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               NIRQ         = 4,
  parameter logic [WIDTH-1:0] HANDLER_BASE = 'h0000_0800,
  parameter int               VEC_SHIFT    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NIRQ-1:0]  irq_in,
  input  logic [NIRQ-1:0]  irq_clr,
  input  logic             eret,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             stall,
  input  logic             ie_in,
  input  logic [WIDTH-1:0] epc_in,
  output logic             cp0_we,
  output logic [4:0]       cp0_w,
  output logic [WIDTH-1:0] cp0_din,
  output logic             ie_one,
  output logic             ie_zero,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             in_service,
  output logic [2:0]       cur_irq
);
  state_t           state;
  logic [WIDTH-1:0] epc_r;
  logic [WIDTH-1:0] cause_val, vec_pc;
  logic [NIRQ-1:0]  ack;
  logic [2:0]       winner;
  logic             any_pending, go;

  assign go  = (state == S_IDLE) && ie_in && any_pending && !stall;
  assign ack = go ? (NIRQ'(1) << winner) : '0;

  irq_prio_latch #(.NIRQ(NIRQ)) u_prio (
    .clk         (clk),
    .clr         (clr),
    .irq_in      (irq_in),
    .irq_clr     (irq_clr),
    .ack         (ack),
    .any_pending (any_pending),
    .winner      (winner)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_IDLE;
      epc_r   <= '0;
      cur_irq <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          state   <= S_SAVE_EPC;
          cur_irq <= winner;
          epc_r   <= pc_next;
        end
        S_SAVE_EPC:   state <= S_SAVE_CAUSE;
        S_SAVE_CAUSE: state <= S_ENTER;
        S_ENTER:      if (!stall) state <= S_IN_SVC;
        S_IN_SVC:     if (eret) state <= S_RETURN;
        S_RETURN:     if (!stall) state <= S_IDLE;
        default:      state <= S_IDLE;
      endcase
    end
  end

  // ExcCode stays zero (Int), so only the IP bit for the serviced line is set.
  assign cause_val = WIDTH'(1) << (CAUSE_IP_BASE + int'(cur_irq));
  assign vec_pc    = HANDLER_BASE + (WIDTH'(cur_irq) << VEC_SHIFT);

  always_comb begin
    cp0_we      = 1'b0;
    cp0_w       = '0;
    cp0_din     = '0;
    ie_one      = 1'b0;
    ie_zero     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    in_service  = 1'b0;
    case (state)
      S_SAVE_EPC: begin
        cp0_we  = 1'b1;
        cp0_w   = CP0_EPC;
        cp0_din = epc_r;
        ie_zero = 1'b1;
      end
      S_SAVE_CAUSE: begin
        cp0_we  = 1'b1;
        cp0_w   = CP0_CAUSE;
        cp0_din = cause_val;
      end
      S_ENTER: begin
        redirect    = 1'b1;
        redirect_pc = vec_pc;
      end
      S_IN_SVC: in_service = 1'b1;
      S_RETURN: begin
        redirect    = 1'b1;
        redirect_pc = epc_in;
        ie_one      = !stall;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Cycle-accurate bench: each scenario queues per-cycle stimulus plus the
// expected output snapshot, then replays it and compares at the falling edge.
module tb_cp0_int_ctrl;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  irq_in = '0, irq_clr = '0;
  logic        eret = 1'b0, stall = 1'b0, ie_in = 1'b0;
  logic [31:0] pc_next = '0, epc_in = '0;
  logic        cp0_we, ie_one, ie_zero, redirect, in_service;
  logic [4:0]  cp0_w;
  logic [31:0] cp0_din, redirect_pc;
  logic [2:0]  cur_irq;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  w;
    logic [31:0] din;
    logic        one;
    logic        zero;
    logic        rd;
    logic [31:0] rpc;
    logic        svc;
    logic [2:0]  cur;
  } outs_t;

  typedef struct packed {
    logic        c;
    logic        ie;
    logic [3:0]  irq;
    logic [3:0]  icl;
    logic        er;
    logic        st;
    logic [31:0] pc;
    logic [31:0] epc;
  } stim_t;

  outs_t exp_q[$];
  logic [31:0] tpc, tepc;

  cp0_int_ctrl dut (
    .clk(clk), .clr(clr), .irq_in(irq_in), .irq_clr(irq_clr), .eret(eret),
    .pc_next(pc_next), .stall(stall), .ie_in(ie_in), .epc_in(epc_in),
    .cp0_we(cp0_we), .cp0_w(cp0_w), .cp0_din(cp0_din), .ie_one(ie_one),
    .ie_zero(ie_zero), .redirect(redirect), .redirect_pc(redirect_pc),
    .in_service(in_service), .cur_irq(cur_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t S(input logic ie, input logic [3:0] irq = 4'd0,
                              input logic [3:0] icl = 4'd0, input logic er = 1'b0,
                              input logic st = 1'b0, input logic c = 1'b0);
    return '{c: c, ie: ie, irq: irq, icl: icl, er: er, st: st, pc: tpc, epc: tepc};
  endfunction

  function automatic outs_t O(input logic we, input logic [4:0] w, input logic [31:0] din,
                              input logic one, input logic zero, input logic rd,
                              input logic [31:0] rpc, input logic svc, input logic [2:0] cur);
    return '{we: we, w: w, din: din, one: one, zero: zero, rd: rd, rpc: rpc, svc: svc, cur: cur};
  endfunction

  function automatic outs_t idle(input logic [2:0] cur);
    return O(0, 5'd0, 0, 0, 0, 0, 0, 0, cur);
  endfunction
  function automatic outs_t w14(input logic [31:0] d, input logic [2:0] cur);
    return O(1, 5'd14, d, 0, 1, 0, 0, 0, cur);
  endfunction
  function automatic outs_t w13(input logic [31:0] d, input logic [2:0] cur);
    return O(1, 5'd13, d, 0, 0, 0, 0, 0, cur);
  endfunction
  function automatic outs_t rdir(input logic [31:0] pc, input logic [2:0] cur);
    return O(0, 5'd0, 0, 0, 0, 1, pc, 0, cur);
  endfunction
  function automatic outs_t sv(input logic [2:0] cur);
    return O(0, 5'd0, 0, 0, 0, 0, 0, 1, cur);
  endfunction
  function automatic outs_t rt(input logic [31:0] pc, input logic one, input logic [2:0] cur);
    return O(0, 5'd0, 0, one, 0, 1, pc, 0, cur);
  endfunction

  task automatic drive(input stim_t s);
    clr = s.c; ie_in = s.ie; irq_in = s.irq; irq_clr = s.icl;
    eret = s.er; stall = s.st; pc_next = s.pc; epc_in = s.epc;
  endtask

  function automatic outs_t obs();
    return O(cp0_we, cp0_w, cp0_din, ie_one, ie_zero, redirect, redirect_pc,
             in_service, cur_irq);
  endfunction

  task automatic test_reset();
    stim_t sq[$];
    outs_t got, e;
    tpc = 32'h0; tepc = 32'h0;
    drive(S(1, 4'd0, 4'd0, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    sq.push_back(S(1)); exp_q.push_back(idle(0));
    sq.push_back(S(1)); exp_q.push_back(idle(0));
    foreach (sq[i]) begin
      drive(sq[i]); @(negedge clk); got = obs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset cyc%0d got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    stim_t sq[$];
    outs_t got, e;
    tpc = 32'h100; tepc = 32'h100;
    sq.push_back(S(1, 4'b0100)); exp_q.push_back(idle(0));
    sq.push_back(S(1));          exp_q.push_back(idle(0));
    sq.push_back(S(1));          exp_q.push_back(w14(32'h100, 2));
    sq.push_back(S(1));          exp_q.push_back(w13(32'h400, 2));
    sq.push_back(S(1));          exp_q.push_back(rdir(32'h820, 2));
    sq.push_back(S(1, 0, 0, 1)); exp_q.push_back(sv(2));
    sq.push_back(S(1));          exp_q.push_back(rt(32'h100, 1, 2));
    sq.push_back(S(1));          exp_q.push_back(idle(2));
    foreach (sq[i]) begin
      drive(sq[i]); @(negedge clk); got = obs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL basic cyc%0d got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    stim_t sq[$];
    outs_t got, e;
    tpc = 32'h200; tepc = 32'h100;
    sq.push_back(S(1, 4'b1010)); exp_q.push_back(idle(2));
    sq.push_back(S(1, 4'b1010)); exp_q.push_back(idle(2));
    sq.push_back(S(1, 4'b1010)); exp_q.push_back(w14(32'h200, 1));
    sq.push_back(S(1));          exp_q.push_back(w13(32'h200, 1));
    sq.push_back(S(1));          exp_q.push_back(rdir(32'h810, 1));
    sq.push_back(S(1, 0, 0, 1)); exp_q.push_back(sv(1));
    sq.push_back(S(1));          exp_q.push_back(rt(32'h100, 1, 1));
    sq.push_back(S(1));          exp_q.push_back(idle(1));
    sq.push_back(S(1));          exp_q.push_back(w14(32'h200, 3));
    sq.push_back(S(1));          exp_q.push_back(w13(32'h800, 3));
    sq.push_back(S(1));          exp_q.push_back(rdir(32'h830, 3));
    sq.push_back(S(1, 0, 0, 1)); exp_q.push_back(sv(3));
    sq.push_back(S(1));          exp_q.push_back(rt(32'h100, 1, 3));
    sq.push_back(S(1));          exp_q.push_back(idle(3));
    foreach (sq[i]) begin
      drive(sq[i]); @(negedge clk); got = obs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL priority cyc%0d got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ie_gate();
    stim_t sq[$];
    outs_t got, e;
    tpc = 32'h300; tepc = 32'h100;
    sq.push_back(S(0, 4'b0001)); exp_q.push_back(idle(3));
    sq.push_back(S(0));          exp_q.push_back(idle(3));
    sq.push_back(S(0));          exp_q.push_back(idle(3));
    sq.push_back(S(1));          exp_q.push_back(idle(3));
    sq.push_back(S(1));          exp_q.push_back(w14(32'h300, 0));
    sq.push_back(S(1));          exp_q.push_back(w13(32'h100, 0));
    sq.push_back(S(1));          exp_q.push_back(rdir(32'h800, 0));
    sq.push_back(S(1, 0, 0, 1)); exp_q.push_back(sv(0));
    sq.push_back(S(1));          exp_q.push_back(rt(32'h100, 1, 0));
    sq.push_back(S(1));          exp_q.push_back(idle(0));
    foreach (sq[i]) begin
      drive(sq[i]); @(negedge clk); got = obs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL ie_gate cyc%0d got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  // Stalls in IDLE, ENTER and RETURN, plus a new request raised during service.
  task automatic test_stall_back_to_back();
    stim_t sq[$];
    outs_t got, e;
    tpc = 32'h400; tepc = 32'h444;
    sq.push_back(S(1, 4'b0100));       exp_q.push_back(idle(0));
    sq.push_back(S(1, 0, 0, 0, 1));    exp_q.push_back(idle(0));
    sq.push_back(S(1));                exp_q.push_back(idle(0));
    sq.push_back(S(1, 0, 0, 0, 1));    exp_q.push_back(w14(32'h400, 2));
    sq.push_back(S(1, 0, 0, 0, 1));    exp_q.push_back(w13(32'h400, 2));
    sq.push_back(S(1, 0, 0, 0, 1));    exp_q.push_back(rdir(32'h820, 2));
    sq.push_back(S(1, 0, 0, 0, 1));    exp_q.push_back(rdir(32'h820, 2));
    sq.push_back(S(1, 0, 0, 0, 1));    exp_q.push_back(rdir(32'h820, 2));
    sq.push_back(S(1));                exp_q.push_back(rdir(32'h820, 2));
    sq.push_back(S(1, 4'b1000, 0, 1)); exp_q.push_back(sv(2));
    sq.push_back(S(1, 0, 0, 0, 1));    exp_q.push_back(rt(32'h444, 0, 2));
    sq.push_back(S(1));                exp_q.push_back(rt(32'h444, 1, 2));
    sq.push_back(S(1));                exp_q.push_back(idle(2));
    sq.push_back(S(1));                exp_q.push_back(w14(32'h400, 3));
    sq.push_back(S(1));                exp_q.push_back(w13(32'h800, 3));
    sq.push_back(S(1));                exp_q.push_back(rdir(32'h830, 3));
    sq.push_back(S(1, 0, 0, 1));       exp_q.push_back(sv(3));
    sq.push_back(S(1));                exp_q.push_back(rt(32'h444, 1, 3));
    sq.push_back(S(1));                exp_q.push_back(idle(3));
    foreach (sq[i]) begin
      drive(sq[i]); @(negedge clk); got = obs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL stall_b2b cyc%0d got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clr_race();
    stim_t sq[$];
    outs_t got, e;
    tpc = 32'h500; tepc = 32'h100;
    sq.push_back(S(0, 4'b0001, 4'b0001)); exp_q.push_back(idle(3));
    sq.push_back(S(1));                   exp_q.push_back(idle(3));
    sq.push_back(S(1));                   exp_q.push_back(w14(32'h500, 0));
    sq.push_back(S(1));                   exp_q.push_back(w13(32'h100, 0));
    sq.push_back(S(1));                   exp_q.push_back(rdir(32'h800, 0));
    sq.push_back(S(1, 0, 0, 1));          exp_q.push_back(sv(0));
    sq.push_back(S(1));                   exp_q.push_back(rt(32'h100, 1, 0));
    sq.push_back(S(0));                   exp_q.push_back(idle(0));
    sq.push_back(S(0, 4'b0001));          exp_q.push_back(idle(0));
    sq.push_back(S(0, 0, 4'b0001));       exp_q.push_back(idle(0));
    sq.push_back(S(1));                   exp_q.push_back(idle(0));
    sq.push_back(S(1));                   exp_q.push_back(idle(0));
    sq.push_back(S(1));                   exp_q.push_back(idle(0));
    foreach (sq[i]) begin
      drive(sq[i]); @(negedge clk); got = obs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL clr_race cyc%0d got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    stim_t sq[$];
    outs_t got, e;
    tpc = 32'h600; tepc = 32'h100;
    sq.push_back(S(1, 4'b0110));          exp_q.push_back(idle(0));
    sq.push_back(S(1));                   exp_q.push_back(idle(0));
    sq.push_back(S(1));                   exp_q.push_back(w14(32'h600, 1));
    sq.push_back(S(1, 0, 0, 0, 0, 1));    exp_q.push_back(w13(32'h200, 1));
    sq.push_back(S(1));                   exp_q.push_back(idle(0));
    sq.push_back(S(1));                   exp_q.push_back(idle(0));
    sq.push_back(S(1));                   exp_q.push_back(idle(0));
    foreach (sq[i]) begin
      drive(sq[i]); @(negedge clk); got = obs(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL mid_reset cyc%0d got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_ie_gate();
    test_stall_back_to_back();
    test_clr_race();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
